// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS core: opcodes, functs,
// ALU control codes, FSM states and the controller-to-datapath control bundle.
package mips_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned OP_W   = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [OP_W-1:0] FN_ADD = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB = 6'h22;
   localparam logic [OP_W-1:0] FN_AND = 6'h24;
   localparam logic [OP_W-1:0] FN_OR  = 6'h25;
   localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctl_t;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
`ifdef MIPS_MULTI_TRAP_EN
      ,
      S_HALT   = 4'd12
`endif
   } state_t;

   // Source of the value captured into ALUOut.
   typedef enum logic [1:0] {
      AO_BRTGT = 2'd0,
      AO_ADDR  = 2'd1,
      AO_RALU  = 2'd2
   } aluo_sel_t;

   typedef struct packed {
      logic      mem_req;
      logic      mem_we;
      logic      addr_alu;
      logic      ir_we;
      logic      pc_inc;
      logic      pc_br;
      logic      pc_jmp;
      logic      ab_we;
      logic      aluo_we;
      aluo_sel_t aluo_sel;
      logic      mdr_we;
      logic      rf_we;
      logic      rf_dst_rd;
      logic      rf_src_mdr;
      logic      retire;
   } ctrl_t;

   function automatic alu_ctl_t alu_ctl(input logic [OP_W-1:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b,
                                           input alu_ctl_t        ctl);
      case (ctl)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SUB: return a - b;
         ALU_SLT: return XLEN'($signed(a) < $signed(b));
         default: return a + b;
      endcase
   endfunction

   function automatic logic is_valid(input logic [OP_W-1:0] op,
                                     input logic [OP_W-1:0] funct);
      case (op)
         OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                          (funct == FN_OR)  || (funct == FN_SLT);
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_multi_ctrl.sv
// Multicycle controller: state sequencing plus per-state enables/selects.
// MIPS_MULTI_TRAP_EN routes unsupported instructions to a sticky HALT state.
module mips_multi_ctrl
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op_i,
   input  logic [OP_W-1:0] funct_i,
   input  logic            mem_ready_i,
   output ctrl_t           ctrl_c_o
`ifdef MIPS_MULTI_TRAP_EN
   ,
   output logic            trap_o
`endif
);

   state_t state_q;
   logic   valid_c;

   assign valid_c = is_valid(op_i, funct_i);

`ifdef MIPS_MULTI_TRAP_EN
   logic trap_q;
   assign trap_o = trap_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
`ifdef MIPS_MULTI_TRAP_EN
         trap_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_FETCH:  if (mem_ready_i) state_q <= S_DECODE;
            S_DECODE: begin
               if (!valid_c) begin
`ifdef MIPS_MULTI_TRAP_EN
                  state_q <= S_HALT;
                  trap_q  <= 1'b1;
`else
                  state_q <= S_FETCH;
`endif
               end else begin
                  case (op_i)
                     OP_LW, OP_SW: state_q <= S_MEMADR;
                     OP_RTYPE:     state_q <= S_EXEC;
                     OP_BEQ:       state_q <= S_BRANCH;
                     OP_ADDI:      state_q <= S_ADDIEX;
                     default:      state_q <= S_JUMP;
                  endcase
               end
            end
            S_MEMADR: state_q <= (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready_i) state_q <= S_MEMWB;
            S_MEMWR:  if (mem_ready_i) state_q <= S_FETCH;
            S_EXEC:   state_q <= S_ALUWB;
            S_ADDIEX: state_q <= S_ADDIWB;
`ifdef MIPS_MULTI_TRAP_EN
            S_HALT:   state_q <= S_HALT;
`endif
            default:  state_q <= S_FETCH;
         endcase
      end
   end

   // Control outputs are a pure decode of the current state (plus ready).
   always_comb begin
      ctrl_c_o          = '0;
      ctrl_c_o.aluo_sel = AO_BRTGT;
      case (state_q)
         S_FETCH: begin
            ctrl_c_o.mem_req = 1'b1;
            ctrl_c_o.ir_we   = mem_ready_i;
            ctrl_c_o.pc_inc  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_c_o.ab_we    = 1'b1;
            ctrl_c_o.aluo_we  = 1'b1;
            ctrl_c_o.aluo_sel = AO_BRTGT;
`ifndef MIPS_MULTI_TRAP_EN
            ctrl_c_o.retire   = !valid_c;
`endif
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl_c_o.aluo_we  = 1'b1;
            ctrl_c_o.aluo_sel = AO_ADDR;
         end
         S_MEMRD: begin
            ctrl_c_o.mem_req  = 1'b1;
            ctrl_c_o.addr_alu = 1'b1;
            ctrl_c_o.mdr_we   = mem_ready_i;
         end
         S_MEMWB: begin
            ctrl_c_o.rf_we      = 1'b1;
            ctrl_c_o.rf_src_mdr = 1'b1;
            ctrl_c_o.retire     = 1'b1;
         end
         S_MEMWR: begin
            ctrl_c_o.mem_req  = 1'b1;
            ctrl_c_o.mem_we   = 1'b1;
            ctrl_c_o.addr_alu = 1'b1;
            ctrl_c_o.retire   = mem_ready_i;
         end
         S_EXEC: begin
            ctrl_c_o.aluo_we  = 1'b1;
            ctrl_c_o.aluo_sel = AO_RALU;
         end
         S_ALUWB: begin
            ctrl_c_o.rf_we     = 1'b1;
            ctrl_c_o.rf_dst_rd = 1'b1;
            ctrl_c_o.retire    = 1'b1;
         end
         S_ADDIWB: begin
            ctrl_c_o.rf_we  = 1'b1;
            ctrl_c_o.retire = 1'b1;
         end
         S_BRANCH: begin
            ctrl_c_o.pc_br  = 1'b1;
            ctrl_c_o.retire = 1'b1;
         end
         S_JUMP: begin
            ctrl_c_o.pc_jmp = 1'b1;
            ctrl_c_o.retire = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multi.sv
// Multicycle MIPS core top: datapath, 32x32 register file and ALU around
// mips_multi_ctrl. Optional trap/HALT support under MIPS_MULTI_TRAP_EN.
module mips_multi
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 32
)(
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic [XLEN-1:0]   pc
`ifdef MIPS_MULTI_TRAP_EN
   ,
   output logic              trap
`endif
);

   ctrl_t ctrl;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ir_q, a_q, b_q, aluo_q, aluo_d, mdr_q;
   logic [XLEN-1:0] rf_q [2**REG_AW];
   logic [XLEN-1:0] sext, rs_val, rt_val, rf_wdata, addr_full;
   logic [REG_AW-1:0] rs, rt, rd, rf_waddr;

   mips_multi_ctrl u_ctrl (
      .clk         (clk),
      .rst_n       (reset),
      .op_i        (ir_q[31:26]),
      .funct_i     (ir_q[5:0]),
      .mem_ready_i (mem_ready),
      .ctrl_c_o    (ctrl)
`ifdef MIPS_MULTI_TRAP_EN
      ,
      .trap_o      (trap)
`endif
   );

   assign rs   = ir_q[25:21];
   assign rt   = ir_q[20:16];
   assign rd   = ir_q[15:11];
   assign sext = {{16{ir_q[15]}}, ir_q[15:0]};

   // Handshake strobes are gated by reset so nothing is requested while held.
   assign mem_req   = ctrl.mem_req & reset;
   assign mem_we    = ctrl.mem_we & reset;
   assign retire    = ctrl.retire & reset;
   assign addr_full = ctrl.addr_alu ? aluo_q : pc_q;
   assign mem_addr  = ADDR_W'({addr_full[XLEN-1:2], 2'b00});
   assign mem_wdata = b_q;
   assign pc        = pc_q;

   assign rs_val   = (rs == '0) ? '0 : rf_q[rs];
   assign rt_val   = (rt == '0) ? '0 : rf_q[rt];
   assign rf_waddr = ctrl.rf_dst_rd ? rd : rt;
   assign rf_wdata = ctrl.rf_src_mdr ? mdr_q : aluo_q;

   always_comb begin
      aluo_d = aluo_q;
      case (ctrl.aluo_sel)
         AO_BRTGT: aluo_d = pc_q + {sext[XLEN-3:0], 2'b00};
         AO_ADDR:  aluo_d = a_q + sext;
         AO_RALU:  aluo_d = alu(a_q, b_q, alu_ctl(ir_q[5:0]));
         default:  aluo_d = aluo_q;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (ctrl.pc_inc)                 pc_d = pc_q + XLEN'(4);
      if (ctrl.pc_br && (a_q == b_q))  pc_d = aluo_q;
      if (ctrl.pc_jmp)                 pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q   <= RESET_PC;
         ir_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         aluo_q <= '0;
         mdr_q  <= '0;
      end else begin
         pc_q <= pc_d;
         if (ctrl.ir_we)   ir_q   <= mem_rdata;
         if (ctrl.ab_we) begin
            a_q <= rs_val;
            b_q <= rt_val;
         end
         if (ctrl.aluo_we) aluo_q <= aluo_d;
         if (ctrl.mdr_we)  mdr_q  <= mem_rdata;
      end
   end

   // Register file keeps its contents across reset; $0 is never written.
   always_ff @(posedge clk) begin
      if (ctrl.rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
   end

endmodule

// File: tb/tb_mips_multi.sv
// Directed program bench for mips_multi with a wait-state memory model.
module tb_mips_multi;

   logic        clk;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, retire;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef MIPS_MULTI_TRAP_EN
   logic        trap;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [31:0] rom [0:255];
   logic [31:0] dmem [0:255];
   bit          valid_w [0:255];
   int          wait_n = 0;
   int          cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   mips_multi #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .retire    (retire),
      .pc        (pc)
`ifdef MIPS_MULTI_TRAP_EN
      ,
      .trap      (trap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unified memory: program image plus words overwritten by stores.
   assign mem_ready = mem_req && (cnt >= wait_n);
   assign mem_rdata = valid_w[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : rom[mem_addr[9:2]];

   always @(posedge clk) begin
      if (!mem_req || mem_ready) cnt <= 0;
      else                       cnt <= cnt + 1;
      if (mem_req && mem_we && mem_ready) begin
         dmem[mem_addr[9:2]]    <= mem_wdata;
         valid_w[mem_addr[9:2]] <= 1'b1;
         wr_addr                <= mem_addr;
         wr_data                <= mem_wdata;
         wr_cnt                 <= wr_cnt + 1;
      end
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one instruction from its first FETCH cycle through its retire cycle.
   task automatic run_instr(input logic [31:0] start, input int exp_cyc, input string tag);
      int          n;
      logic        pw;
      logic        pwe;
      logic [31:0] pa;
      chk(32'(mem_req), 32'd1, {tag, " fetch req"});
      chk(mem_addr, start, {tag, " fetch addr"});
      n   = 1;
      pw  = mem_req && !mem_ready;
      pa  = mem_addr;
      pwe = mem_we;
      while (retire !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (pw) begin
            chk(32'(mem_req), 32'd1, {tag, " req held"});
            chk(mem_addr, pa, {tag, " addr held"});
            chk(32'(mem_we), 32'(pwe), {tag, " we held"});
         end
         pw  = mem_req && !mem_ready;
         pa  = mem_addr;
         pwe = mem_we;
      end
      chk(32'(n), 32'(exp_cyc), {tag, " cycles"});
      chk(pc, start + 32'd4, {tag, " pc"});
      @(negedge clk);
   endtask

   initial begin
      bit found;
      int wr_save;
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;
      rom[0]  = 32'h2001_0005;  // addi $1,$0,5
      rom[1]  = 32'h0021_1020;  // add  $2,$1,$1
      rom[2]  = 32'hAC02_0008;  // sw   $2,8($0)
      rom[3]  = 32'h8C03_0008;  // lw   $3,8($0)
      rom[4]  = 32'h0800_0040;  // j    0x40 -> 0x100
      rom[8]  = 32'h1021_FFFF;  // beq  $1,$1,-1
      rom[9]  = 32'h0022_2022;  // sub  $4,$1,$2
      rom[10] = 32'h0081_282A;  // slt  $5,$4,$1
      rom[11] = 32'h0022_3025;  // or   $6,$1,$2
      rom[12] = 32'h00C1_3824;  // and  $7,$6,$1
      rom[13] = 32'hAC04_0210;  // sw   $4,0x210($0)
      rom[14] = 32'hAC05_0214;  // sw   $5,0x214($0)
      rom[15] = 32'hAC06_0218;  // sw   $6,0x218($0)
      rom[16] = 32'hAC07_021C;  // sw   $7,0x21C($0)
      rom[17] = 32'h0000_003F;  // unsupported funct
      rom[18] = 32'h8C08_0200;  // lw   $8,0x200($0)
      rom[64] = 32'h2000_0007;  // addi $0,$0,7
      rom[65] = 32'hAC03_0200;  // sw   $3,0x200($0)
      rom[66] = 32'hAC00_0204;  // sw   $0,0x204($0)
      rom[67] = 32'h0800_0008;  // j    0x20

      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk(32'(mem_req), 32'd0, "reset req");
      chk(32'(mem_we), 32'd0, "reset we");
      chk(32'(retire), 32'd0, "reset retire");
      chk(pc, 32'h0, "reset pc");
      reset = 1'b1;
      #1;
      chk(32'(mem_we), 32'd0, "first fetch we");

      run_instr(32'h00, 4, "addi");
      run_instr(32'h04, 4, "add");

      wait_n = 3;
      #1;
      run_instr(32'h08, 10, "sw waits");
      chk(wr_addr, 32'h8, "sw addr");
      chk(wr_data, 32'd10, "sw data");
      run_instr(32'h0C, 11, "lw waits");

      wait_n = 0;
      #1;
      run_instr(32'h10, 3, "j");
      run_instr(32'h100, 4, "addi r0");
      run_instr(32'h104, 4, "sw r3");
      chk(wr_addr, 32'h200, "sw r3 addr");
      chk(wr_data, 32'd10, "lw result");
      run_instr(32'h108, 4, "sw r0");
      chk(wr_data, 32'd0, "r0 reads 0");
      run_instr(32'h10C, 3, "j back");

      run_instr(32'h20, 3, "beq taken");
      rom[8] = 32'h1022_FFFF;  // beq $1,$2,-1
      run_instr(32'h20, 3, "beq not taken");
      run_instr(32'h24, 4, "sub");
      run_instr(32'h28, 4, "slt");
      run_instr(32'h2C, 4, "or");
      run_instr(32'h30, 4, "and");
      run_instr(32'h34, 4, "sw sub");
      chk(wr_data, 32'hFFFF_FFFB, "sub result");
      run_instr(32'h38, 4, "sw slt");
      chk(wr_data, 32'd1, "slt result");
      run_instr(32'h3C, 4, "sw or");
      chk(wr_data, 32'd15, "or result");
      run_instr(32'h40, 4, "sw and");
      chk(wr_data, 32'd5, "and result");
      wr_save = wr_cnt;

`ifdef MIPS_MULTI_TRAP_EN
      chk(32'(trap), 32'd0, "trap idle");
      repeat (3) @(negedge clk);
      chk(32'(trap), 32'd1, "trap set");
      chk(32'(mem_req), 32'd0, "halt req");
      chk(32'(retire), 32'd0, "halt retire");
      repeat (3) @(negedge clk);
      chk(32'(trap), 32'd1, "trap sticky");
      chk(32'(mem_req), 32'd0, "halt req sticky");
      reset = 1'b0;
      #1;
      chk(32'(trap), 32'd0, "trap cleared");
`else
      run_instr(32'h44, 2, "nop");
      wait_n = 5;
      #1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_addr === 32'h200) found = 1'b1;
      end
      chk(32'(found), 32'd1, "memrd reached");
      @(negedge clk);
      chk(32'(mem_ready), 32'd0, "memrd waiting");
      reset = 1'b0;
      #1;
`endif
      chk(32'(mem_req), 32'd0, "abort req");
      chk(32'(mem_we), 32'd0, "abort we");
      chk(32'(retire), 32'd0, "abort retire");
      chk(pc, 32'h0, "abort pc");
      repeat (2) @(negedge clk);
      chk(32'(mem_req), 32'd0, "held req");
      chk(32'(wr_cnt), 32'(wr_save), "no stray write");
      reset  = 1'b1;
      wait_n = 0;
      #1;
      run_instr(32'h00, 4, "refetch addi");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
